alustage3: RTL and testbench

- Execute stage directly downstream of registersstage2; consumes its outbound_instruction.
- Decodes ALU, branch and register-jump instructions and reads up to two operands from the register file.
- Drives the register file write port with results, keeps the CPU condition flags, and drives program_counter jump/branch.
- Holds the earlier stages with `stall` during multi-cycle multiply.

---
 rtl/alustage3_pkg.sv | 73 +++++++
 rtl/alustage3_alu.sv | 53 +++++
 rtl/alustage3.sv | 188 ++++++++++++++++++
 tb/tb_alustage3.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alustage3_pkg.sv
// alustage3_pkg: shared types and constants for the execute stage.
//   t_reg / t_reg_index : register file data word and register index
//   t_alu_op            : 4-bit ALU operation field
//   t_branch_cond       : 4-bit branch condition field (9-15 never taken)
//   OP_*                : primary opcodes, instruction bits [31:26]
//   FLAG_*              : bit positions inside the {N,Z,C,V} flags word
//   branch_taken()      : evaluates a branch condition against the flags
package alustage3_pkg;

   typedef logic [31:0] t_reg;
   typedef logic [3:0]  t_reg_index;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_ADDC  = 4'd1,
      ALU_SUB   = 4'd2,
      ALU_SUBC  = 4'd3,
      ALU_AND   = 4'd4,
      ALU_OR    = 4'd5,
      ALU_XOR   = 4'd6,
      ALU_COPY  = 4'd7,
      ALU_LSL   = 4'd8,
      ALU_LSR   = 4'd9,
      ALU_ASR   = 4'd10,
      ALU_MULU  = 4'd11,
      ALU_CMP   = 4'd12,
      ALU_RSV13 = 4'd13,
      ALU_RSV14 = 4'd14,
      ALU_RSV15 = 4'd15
   } t_alu_op;

   typedef enum logic [3:0] {
      BR_ALWAYS = 4'd0,
      BR_EQ     = 4'd1,
      BR_NE     = 4'd2,
      BR_CS     = 4'd3,
      BR_CC     = 4'd4,
      BR_MI     = 4'd5,
      BR_PL     = 4'd6,
      BR_VS     = 4'd7,
      BR_VC     = 4'd8,
      BR_NEVER  = 4'd15
   } t_branch_cond;

   localparam logic [5:0] OP_ALU_REG  = 6'h10;
   localparam logic [5:0] OP_ALU_IMM  = 6'h11;
   localparam logic [5:0] OP_BRANCH   = 6'h20;
   localparam logic [5:0] OP_JUMP_REG = 6'h21;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic branch_taken(input logic [3:0] cond, input logic [3:0] f);
      logic taken;
      taken = 1'b0;
      case (cond)
         BR_ALWAYS: taken = 1'b1;
         BR_EQ:     taken = f[FLAG_Z];
         BR_NE:     taken = !f[FLAG_Z];
         BR_CS:     taken = f[FLAG_C];
         BR_CC:     taken = !f[FLAG_C];
         BR_MI:     taken = f[FLAG_N];
         BR_PL:     taken = !f[FLAG_N];
         BR_VS:     taken = f[FLAG_V];
         BR_VC:     taken = !f[FLAG_V];
         default:   taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/alustage3_alu.sv
// alu: purely combinational ALU used by alustage3.
//   a, b      : operands
//   op        : t_alu_op
//   carry_in  : C flag, consumed by ADDC (carry) and SUBC (borrow)
//   result    : 32-bit result (0 for MULU and reserved ops)
//   nzcv      : {N,Z,C,V} from this result; the caller picks which bits apply
module alu
   import alustage3_pkg::*;
(
   input  t_reg        a,
   input  t_reg        b,
   input  t_alu_op     op,
   input  logic        carry_in,
   output t_reg        result,
   output logic [3:0]  nzcv
);

   logic [32:0] wide;
   logic        c;
   logic        v;

   always_comb begin
      wide   = '0;
      result = '0;
      c      = 1'b0;
      v      = 1'b0;
      case (op)
         ALU_ADD, ALU_ADDC: begin
            wide   = {1'b0, a} + {1'b0, b} + {32'd0, (op == ALU_ADDC) & carry_in};
            result = wide[31:0];
            c      = wide[32];
            v      = (a[31] == b[31]) && (result[31] != a[31]);
         end
         ALU_SUB, ALU_SUBC, ALU_CMP: begin
            // Bit 32 of the 33-bit difference is the borrow out.
            wide   = {1'b0, a} - {1'b0, b} - {32'd0, (op == ALU_SUBC) & carry_in};
            result = wide[31:0];
            c      = wide[32];
            v      = (a[31] != b[31]) && (result[31] != a[31]);
         end
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_COPY: result = b;
         ALU_LSL:  result = a << b[4:0];
         ALU_LSR:  result = a >> b[4:0];
         ALU_ASR:  result = t_reg'($signed(a) >>> b[4:0]);
         default:  result = '0;
      endcase
      nzcv = {result[31], (result == '0), c, v};
   end

endmodule

// File: rtl/alustage3.sv
// alustage3: execute stage downstream of registersstage2.
//   clock, reset (async, active low)
//   inbound_instruction          : next instruction, captured when stall=0
//   operand_a/b_index, _data     : combinational register file read port
//   write, write_index, write_data : one-cycle register file write
//   jump, jump_data              : one-cycle register jump to program_counter
//   branch, branch_data          : one-cycle taken-branch strobe and offset
//   stall                        : holds upstream stages and program counter
//   flags                        : {N,Z,C,V}
//   outbound_instruction         : registered pass-through, 0 while stalled
// Build option: define ALUSTAGE3_MULTIPLY_EN to build the shift-add MULU
// unit (IDLE/MUL FSM, state visible as state_q); otherwise aluop 11 is a
// reserved no-op and stall is tied low.
module alustage3
   import alustage3_pkg::*;
#(
   parameter int MUL_STEPS = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] inbound_instruction,
   output t_reg_index  operand_a_index,
   output t_reg_index  operand_b_index,
   input  t_reg        operand_a_data,
   input  t_reg        operand_b_data,
   output t_reg_index  write_index,
   output logic        write,
   output t_reg        write_data,
   output logic        jump,
   output t_reg        jump_data,
   output logic        branch,
   output logic [15:0] branch_data,
   output logic        stall,
   output logic [3:0]  flags,
   output logic [31:0] outbound_instruction
);

   // Flow control: an inbound instruction is consumed on every rising edge
   // where stall is low; while stall is high upstream holds it unchanged and
   // this stage ignores it.
   logic [31:0] instr_q;
   logic [5:0]  opcode;
   logic        is_alu;
   logic        is_branch;
   logic        is_jump;
   logic [3:0]  aluop_raw;
   t_alu_op     alu_op;
   t_reg        alu_b;
   t_reg        alu_result;
   logic [3:0]  alu_nzcv;
   logic        alu_writes;
   logic [3:0]  alu_flags_next;

   assign opcode          = instr_q[31:26];
   assign is_alu          = (opcode == OP_ALU_REG) || (opcode == OP_ALU_IMM);
   assign is_branch       = (opcode == OP_BRANCH);
   assign is_jump         = (opcode == OP_JUMP_REG);
   assign operand_a_index = instr_q[21:18];
   assign operand_b_index = instr_q[17:14];
   assign aluop_raw       = (opcode == OP_ALU_IMM) ? instr_q[17:14] : instr_q[13:10];
   assign alu_op          = t_alu_op'(aluop_raw);
   assign alu_b           = (opcode == OP_ALU_IMM) ? {{18{instr_q[13]}}, instr_q[13:0]}
                                                   : operand_b_data;

   alu u_alu (
      .a        (operand_a_data),
      .b        (alu_b),
      .op       (alu_op),
      .carry_in (flags[FLAG_C]),
      .result   (alu_result),
      .nzcv     (alu_nzcv)
   );

   // Which results are written and which flag bits they touch.
   always_comb begin
      alu_writes     = 1'b0;
      alu_flags_next = flags;
      case (alu_op)
         ALU_ADD, ALU_ADDC, ALU_SUB, ALU_SUBC: begin
            alu_writes     = 1'b1;
            alu_flags_next = alu_nzcv;
         end
         ALU_CMP: alu_flags_next = alu_nzcv;
         ALU_AND, ALU_OR, ALU_XOR, ALU_COPY, ALU_LSL, ALU_LSR, ALU_ASR: begin
            alu_writes     = 1'b1;
            alu_flags_next = {alu_nzcv[FLAG_N], alu_nzcv[FLAG_Z], flags[FLAG_C], flags[FLAG_V]};
         end
         default: ;
      endcase
   end

`ifdef ALUSTAGE3_MULTIPLY_EN
   localparam int CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

   logic [0:0]    state_q;
   t_reg          mcand_q;
   t_reg          mplier_q;
   t_reg          acc_q;
   logic [CW-1:0] count_q;
   logic          mul_hold;
   t_reg          acc_sum;

   assign mul_hold = is_alu && (alu_op == ALU_MULU);
   assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
   // The IDLE cycle holding a MULU stalls too, so the operands stay valid
   // until they are latched.
   assign stall    = (state_q == ST_MUL) || mul_hold;
`else
   assign stall    = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         instr_q              <= '0;
         write                <= 1'b0;
         write_index          <= '0;
         write_data           <= '0;
         jump                 <= 1'b0;
         jump_data            <= '0;
         branch               <= 1'b0;
         branch_data          <= '0;
         flags                <= '0;
         outbound_instruction <= '0;
`ifdef ALUSTAGE3_MULTIPLY_EN
         state_q              <= ST_IDLE;
         mcand_q              <= '0;
         mplier_q             <= '0;
         acc_q                <= '0;
         count_q              <= '0;
`endif
      end else begin
         write                <= 1'b0;
         jump                 <= 1'b0;
         branch               <= 1'b0;
         outbound_instruction <= stall ? '0 : instr_q;
         if (!stall) begin
            instr_q <= inbound_instruction;
            if (is_alu) begin
               flags <= alu_flags_next;
               if (alu_writes) begin
                  write       <= 1'b1;
                  write_index <= instr_q[25:22];
                  write_data  <= alu_result;
               end
            end
            if (is_branch && branch_taken(instr_q[25:22], flags)) begin
               branch      <= 1'b1;
               branch_data <= instr_q[15:0];
            end
            if (is_jump) begin
               jump      <= 1'b1;
               jump_data <= operand_a_data;
            end
         end
`ifdef ALUSTAGE3_MULTIPLY_EN
         case (state_q)
            ST_IDLE: begin
               if (mul_hold) begin
                  mcand_q  <= operand_a_data;
                  mplier_q <= alu_b;
                  acc_q    <= '0;
                  count_q  <= CW'(MUL_STEPS - 1);
                  state_q  <= ST_MUL;
               end
            end
            default: begin
               acc_q    <= acc_sum;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q - 1'b1;
               if (count_q == '0) begin
                  write       <= 1'b1;
                  write_index <= instr_q[25:22];
                  write_data  <= acc_sum;
                  flags       <= {acc_sum[31], (acc_sum == '0), flags[FLAG_C], flags[FLAG_V]};
                  state_q     <= ST_IDLE;
                  // Retire the MULU so it is not restarted when stall drops.
                  instr_q     <= '0;
               end
            end
         endcase
`endif
      end
   end

endmodule

// File: tb/tb_alustage3.sv
// tb_alustage3: directed self-checking bench for alustage3. A small register
// file array supplies operand data; expected values are hand-computed.
// The multiply scenario runs when ALUSTAGE3_MULTIPLY_EN is defined, the
// disabled-multiply scenario otherwise.
module tb_alustage3;

   logic        clock;
   logic        reset;
   logic [31:0] inbound_instruction;
   logic [3:0]  operand_a_index;
   logic [3:0]  operand_b_index;
   logic [31:0] operand_a_data;
   logic [31:0] operand_b_data;
   logic [3:0]  write_index;
   logic        write;
   logic [31:0] write_data;
   logic        jump;
   logic [31:0] jump_data;
   logic        branch;
   logic [15:0] branch_data;
   logic        stall;
   logic [3:0]  flags;
   logic [31:0] outbound_instruction;

   logic [31:0] regs [16];
   int          pass_cnt;
   int          total_cnt;

   assign operand_a_data = regs[operand_a_index];
   assign operand_b_data = regs[operand_b_index];

   alustage3 dut (
      .clock                (clock),
      .reset                (reset),
      .inbound_instruction  (inbound_instruction),
      .operand_a_index      (operand_a_index),
      .operand_b_index      (operand_b_index),
      .operand_a_data       (operand_a_data),
      .operand_b_data       (operand_b_data),
      .write_index          (write_index),
      .write                (write),
      .write_data           (write_data),
      .jump                 (jump),
      .jump_data            (jump_data),
      .branch               (branch),
      .branch_data          (branch_data),
      .stall                (stall),
      .flags                (flags),
      .outbound_instruction (outbound_instruction)
   );

   // Clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Instruction encoders
   function automatic logic [31:0] enc_reg(input logic [3:0] op, input logic [3:0] d,
                                           input logic [3:0] a, input logic [3:0] b);
      return {6'h10, d, a, b, op, 10'd0};
   endfunction
   function automatic logic [31:0] enc_imm(input logic [3:0] op, input logic [3:0] d,
                                           input logic [3:0] a, input logic [13:0] imm);
      return {6'h11, d, a, op, imm};
   endfunction
   function automatic logic [31:0] enc_br(input logic [3:0] cond, input logic [15:0] off);
      return {6'h20, cond, 6'd0, off};
   endfunction
   function automatic logic [31:0] enc_jr(input logic [3:0] a);
      return {6'h21, 4'd0, a, 18'd0};
   endfunction

   // Driver: called at a falling edge; presents instr for one capture edge,
   // then a NOP, and returns at the falling edge after the execute edge.
   task automatic issue(input logic [31:0] instr);
      inbound_instruction = instr;
      @(negedge clock);
      inbound_instruction = 32'd0;
      @(negedge clock);
   endtask

   task automatic test_reset();
      total_cnt++;
      if ({write, jump, branch, stall} !== 4'b0000) $display("FAIL reset_strobes got %b exp 0000", {write, jump, branch, stall});
      else pass_cnt++;
      total_cnt++;
      if (flags !== 4'b0000) $display("FAIL reset_flags got %b exp 0000", flags);
      else pass_cnt++;
      total_cnt++;
      if ({write_data, jump_data, branch_data, outbound_instruction, write_index} !== '0)
         $display("FAIL reset_data got %h/%h/%h/%h/%h exp all zero", write_data, jump_data, branch_data, outbound_instruction, write_index);
      else pass_cnt++;
   endtask

   task automatic test_add();
      regs[1] = 32'd5;
      regs[2] = 32'd7;
      issue(enc_reg(4'd0, 4'd3, 4'd1, 4'd2));
      total_cnt++;
      if ({write, write_index, write_data} !== {1'b1, 4'd3, 32'd12})
         $display("FAIL add_write got w=%b idx=%0d data=%h exp w=1 idx=3 data=0000000c", write, write_index, write_data);
      else pass_cnt++;
      total_cnt++;
      if (flags !== 4'b0000) $display("FAIL add_flags got %b exp 0000", flags);
      else pass_cnt++;
      total_cnt++;
      if (outbound_instruction !== enc_reg(4'd0, 4'd3, 4'd1, 4'd2))
         $display("FAIL add_outbound got %h exp %h", outbound_instruction, enc_reg(4'd0, 4'd3, 4'd1, 4'd2));
      else pass_cnt++;
      @(negedge clock);
      total_cnt++;
      if (write !== 1'b0) $display("FAIL add_one_cycle got %b exp 0", write);
      else pass_cnt++;
   endtask

   task automatic test_imm_add();
      regs[1] = 32'h7FFF_FFFF;
      issue(enc_imm(4'd0, 4'd4, 4'd1, 14'd1));
      total_cnt++;
      if ({write, write_index, write_data} !== {1'b1, 4'd4, 32'h8000_0000})
         $display("FAIL imm_add_write got w=%b idx=%0d data=%h exp w=1 idx=4 data=80000000", write, write_index, write_data);
      else pass_cnt++;
      total_cnt++;
      if (flags !== 4'b1001) $display("FAIL imm_add_flags got %b exp 1001", flags);
      else pass_cnt++;
   endtask

   task automatic test_cmp_branch(input logic [3:0] cond, input logic exp_taken);
      regs[1] = 32'd3;
      regs[2] = 32'd3;
      inbound_instruction = enc_reg(4'd12, 4'd0, 4'd1, 4'd2);
      @(negedge clock);
      inbound_instruction = enc_br(cond, 16'hFFF0);
      @(negedge clock);
      inbound_instruction = 32'd0;
      total_cnt++;
      if (write !== 1'b0) $display("FAIL cmp_no_write cond=%0d got %b exp 0", cond, write);
      else pass_cnt++;
      total_cnt++;
      if (flags !== 4'b0100) $display("FAIL cmp_flags cond=%0d got %b exp 0100", cond, flags);
      else pass_cnt++;
      @(negedge clock);
      total_cnt++;
      if (branch !== exp_taken) $display("FAIL branch_strobe cond=%0d got %b exp %b", cond, branch, exp_taken);
      else pass_cnt++;
      if (exp_taken) begin
         total_cnt++;
         if (branch_data !== 16'hFFF0) $display("FAIL branch_data got %h exp fff0", branch_data);
         else pass_cnt++;
      end
      @(negedge clock);
      total_cnt++;
      if (branch !== 1'b0) $display("FAIL branch_one_cycle cond=%0d got %b exp 0", cond, branch);
      else pass_cnt++;
   endtask

   task automatic test_logic_shift();
      regs[1] = 32'd3;
      regs[8] = 32'h8000_0000;
      // 3 - 7 borrows: N=1 C=1
      issue(enc_imm(4'd2, 4'd7, 4'd1, 14'd7));
      total_cnt++;
      if ({write_data, flags} !== {32'hFFFF_FFFC, 4'b1010})
         $display("FAIL sub_borrow got data=%h flags=%b exp fffffffc 1010", write_data, flags);
      else pass_cnt++;
      // Shifts leave C/V alone
      issue(enc_imm(4'd9, 4'd9, 4'd8, 14'd4));
      total_cnt++;
      if ({write_index, write_data, flags} !== {4'd9, 32'h0800_0000, 4'b0010})
         $display("FAIL lsr got idx=%0d data=%h flags=%b exp 9 08000000 0010", write_index, write_data, flags);
      else pass_cnt++;
      issue(enc_imm(4'd10, 4'd10, 4'd8, 14'd4));
      total_cnt++;
      if ({write_data, flags} !== {32'hF800_0000, 4'b1010})
         $display("FAIL asr got data=%h flags=%b exp f8000000 1010", write_data, flags);
      else pass_cnt++;
      issue(enc_reg(4'd6, 4'd11, 4'd8, 4'd8));
      total_cnt++;
      if ({write, write_data, flags} !== {1'b1, 32'd0, 4'b0110})
         $display("FAIL xor_zero got w=%b data=%h flags=%b exp 1 00000000 0110", write, write_data, flags);
      else pass_cnt++;
      // C=1 here, so 3 + 3 + 1
      regs[2] = 32'd3;
      issue(enc_reg(4'd1, 4'd12, 4'd1, 4'd2));
      total_cnt++;
      if ({write_data, flags} !== {32'd7, 4'b0000})
         $display("FAIL addc got data=%h flags=%b exp 00000007 0000", write_data, flags);
      else pass_cnt++;
   endtask

   task automatic test_jump();
      regs[6] = 32'h1234_5678;
      issue(enc_jr(4'd6));
      total_cnt++;
      if ({jump, jump_data, write} !== {1'b1, 32'h1234_5678, 1'b0})
         $display("FAIL jump got j=%b data=%h w=%b exp 1 12345678 0", jump, jump_data, write);
      else pass_cnt++;
      @(negedge clock);
      total_cnt++;
      if (jump !== 1'b0) $display("FAIL jump_one_cycle got %b exp 0", jump);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      regs[1] = 32'd5;
      regs[2] = 32'd7;
      inbound_instruction = enc_reg(4'd0, 4'd3, 4'd1, 4'd2);
      @(negedge clock);
      inbound_instruction = enc_imm(4'd2, 4'd4, 4'd2, 14'd2);
      @(negedge clock);
      inbound_instruction = 32'd0;
      total_cnt++;
      if ({write, write_index, write_data} !== {1'b1, 4'd3, 32'd12})
         $display("FAIL b2b_first got w=%b idx=%0d data=%h exp 1 3 0000000c", write, write_index, write_data);
      else pass_cnt++;
      @(negedge clock);
      total_cnt++;
      if ({write, write_index, write_data, flags} !== {1'b1, 4'd4, 32'd5, 4'b0000})
         $display("FAIL b2b_second got w=%b idx=%0d data=%h flags=%b exp 1 4 00000005 0000", write, write_index, write_data, flags);
      else pass_cnt++;
      @(negedge clock);
      total_cnt++;
      if (write !== 1'b0) $display("FAIL b2b_idle got %b exp 0", write);
      else pass_cnt++;
   endtask

   // CMP r2,r1 = 5 - 0x10003: negative with borrow, flags 1010
   task automatic set_flags_1010();
      regs[1] = 32'h0001_0003;
      regs[2] = 32'd5;
      issue(enc_reg(4'd12, 4'd0, 4'd2, 4'd1));
      total_cnt++;
      if (flags !== 4'b1010) $display("FAIL cmp_setup_flags got %b exp 1010", flags);
      else pass_cnt++;
   endtask

`ifdef ALUSTAGE3_MULTIPLY_EN
   task automatic test_mulu();
      int n;
      int bad;
      set_flags_1010();
      inbound_instruction = enc_reg(4'd11, 4'd5, 4'd1, 4'd2);
      @(negedge clock);
      // A jump presented during the stall must not execute
      inbound_instruction = enc_jr(4'd6);
      n = 0;
      bad = 0;
      while (stall === 1'b1 && n < 100) begin
         if (write !== 1'b0 || jump !== 1'b0) bad++;
         n++;
         @(negedge clock);
      end
      inbound_instruction = 32'd0;
      total_cnt++;
      if (n !== 33) $display("FAIL mul_stall_cycles got %0d exp 33", n);
      else pass_cnt++;
      total_cnt++;
      if (bad !== 0) $display("FAIL mul_quiet_during_stall got %0d strobes exp 0", bad);
      else pass_cnt++;
      total_cnt++;
      if ({write, write_index, write_data} !== {1'b1, 4'd5, 32'h0005_000F})
         $display("FAIL mul_result got w=%b idx=%0d data=%h exp 1 5 0005000f", write, write_index, write_data);
      else pass_cnt++;
      total_cnt++;
      if (flags !== 4'b0010) $display("FAIL mul_flags got %b exp 0010", flags);
      else pass_cnt++;
      @(negedge clock);
      total_cnt++;
      if ({write, jump, stall} !== 3'b000) $display("FAIL mul_after got w/j/s=%b exp 000", {write, jump, stall});
      else pass_cnt++;
   endtask
`else
   task automatic test_mulu_disabled();
      set_flags_1010();
      inbound_instruction = enc_reg(4'd11, 4'd5, 4'd1, 4'd2);
      @(negedge clock);
      inbound_instruction = 32'd0;
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL mulu_off_stall got %b exp 0", stall);
      else pass_cnt++;
      @(negedge clock);
      total_cnt++;
      if ({write, stall, flags} !== {1'b0, 1'b0, 4'b1010})
         $display("FAIL mulu_off_exec got w=%b s=%b flags=%b exp 0 0 1010", write, stall, flags);
      else pass_cnt++;
   endtask
`endif

   task automatic test_reset_mid_mul();
      regs[1] = 32'h0001_0003;
      regs[2] = 32'd5;
      inbound_instruction = enc_reg(4'd11, 4'd5, 4'd1, 4'd2);
      @(negedge clock);
      inbound_instruction = 32'd0;
      repeat (10) @(negedge clock);
`ifdef ALUSTAGE3_MULTIPLY_EN
      total_cnt++;
      if (stall !== 1'b1) $display("FAIL mid_mul_stalled got %b exp 1", stall);
      else pass_cnt++;
`endif
      reset = 1'b0;
      #1;
      total_cnt++;
      if ({stall, write, jump, branch, flags} !== 8'd0)
         $display("FAIL async_reset got s/w/j/b=%b flags=%b exp 0000 0000", {stall, write, jump, branch}, flags);
      else pass_cnt++;
      total_cnt++;
      if ({write_data, outbound_instruction} !== 64'd0)
         $display("FAIL async_reset_data got %h/%h exp 0/0", write_data, outbound_instruction);
      else pass_cnt++;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL post_reset_stall got %b exp 0", stall);
      else pass_cnt++;
      regs[1] = 32'd5;
      regs[2] = 32'd7;
      issue(enc_reg(4'd0, 4'd3, 4'd1, 4'd2));
      total_cnt++;
      if ({write, write_index, write_data, flags} !== {1'b1, 4'd3, 32'd12, 4'b0000})
         $display("FAIL post_reset_add got w=%b idx=%0d data=%h flags=%b exp 1 3 0000000c 0000", write, write_index, write_data, flags);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      reset = 1'b0;
      inbound_instruction = 32'd0;
      for (int i = 0; i < 16; i++) regs[i] = 32'd0;
      repeat (3) @(negedge clock);
      test_reset();
      reset = 1'b1;
      @(negedge clock);
      test_add();
      test_imm_add();
      test_cmp_branch(4'd1, 1'b1);
      test_cmp_branch(4'd2, 1'b0);
      test_logic_shift();
      test_jump();
      test_back_to_back();
`ifdef ALUSTAGE3_MULTIPLY_EN
      test_mulu();
`else
      test_mulu_disabled();
`endif
      test_reset_mid_mul();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
